// File: rtl/led_flash_driver.sv
// led_flash_driver: timed LED flash FSM (IDLE/ON/OFF) with drop reporting.
// Define LED_FLASH_QUEUE_EN to queue up to QUEUE_MAX triggers that arrive mid-flash.
module led_flash_driver #(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 25_000_000,
    parameter int QUEUE_MAX  = 7
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_trig,
    output logic                             o_led,
    output logic                             o_busy,
    output logic [$clog2(QUEUE_MAX+1)-1:0]   o_pending,
    output logic                             o_drop
);
    localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int PW   = $clog2(QUEUE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          led_q, drop_q, drop_d;
    logic          start, on_last, off_last;

    assign on_last  = (state_q == ON)  && (timer_q == TW'(ON_CYCLES - 1));
    assign off_last = (state_q == OFF) && (timer_q == TW'(OFF_CYCLES - 1));

`ifdef LED_FLASH_QUEUE_EN
    logic [PW-1:0] pend_q, pend_d;
    logic          dec, consume, enq, acc;
    // A trigger on the last OFF cycle with an empty queue starts the next flash directly.
    assign dec     = off_last && (pend_q != '0);
    assign consume = (state_q == IDLE) || (off_last && (pend_q == '0));
    assign enq     = i_trig && !consume;
    assign acc     = enq && ((pend_q != PW'(QUEUE_MAX)) || dec);
    assign pend_d  = pend_q + PW'(acc) - PW'(dec);
    assign start   = ((state_q == IDLE) && i_trig) || (off_last && (dec || i_trig));
    assign drop_d  = enq && !acc;
    assign o_pending = pend_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end
`else
    assign start     = (state_q == IDLE) && i_trig;
    assign drop_d    = i_trig && (state_q != IDLE);
    assign o_pending = '0;
`endif

    assign state_d = start ? ON : on_last ? OFF : off_last ? IDLE : state_q;
    assign timer_d = ((state_q == IDLE) || on_last || off_last) ? '0 : timer_q + TW'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            led_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            led_q   <= (state_d == ON);
            drop_q  <= drop_d;
        end
    end

    assign o_led  = led_q;
    assign o_busy = (state_q != IDLE);
    assign o_drop = drop_q;
endmodule

// File: tb/tb_led_flash_driver.sv
// tb_led_flash_driver: directed checks of flash timing, drops, queueing and async reset.
module tb_led_flash_driver;
    localparam int ONC = 4;
    localparam int OFFC = 3;
    localparam int QM = 2;
    localparam int PW = $clog2(QM + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          trig = 1'b0;
    logic          led, busy, drop;
    logic [PW-1:0] pend;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    led_flash_driver #(.ON_CYCLES(ONC), .OFF_CYCLES(OFFC), .QUEUE_MAX(QM)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig),
        .o_led(led), .o_busy(busy), .o_pending(pend), .o_drop(drop)
    );

    // Drive trig for one cycle; return #1 after the edge so outputs show the next cycle.
    task automatic step(input logic t);
        trig = t;
        @(posedge clk);
        #1;
        trig = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [PW+2:0] exp;
        exp = '0;
        #2;
        checks++;
        if ({led, busy, drop, pend} !== exp) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", {led, busy, drop, pend}, exp);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0);
            checks++;
            if ({led, busy, drop, pend} !== exp) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got %b expected %b", k, {led, busy, drop, pend}, exp);
            end
        end
    endtask

    task automatic test_single();
        logic [PW-1:0] zp;
        logic el, eb;
        zp = '0;
        do_reset();
        for (int c = 10; c <= 21; c++) begin
            step(c == 10);
            el = (c + 1 >= 11) && (c + 1 <= 14);
            eb = (c + 1 >= 11) && (c + 1 <= 17);
            checks++;
            if ({led, busy, drop, pend} !== {el, eb, 1'b0, zp}) begin
                errors++;
                $display("FAIL single cycle %0d: got %b expected %b", c + 1, {led, busy, drop, pend}, {el, eb, 1'b0, zp});
            end
        end
    endtask

    task automatic test_noqueue_drop();
        logic [PW-1:0] zp;
        logic el, eb, ed;
        int o;
        zp = '0;
        do_reset();
        for (int c = 10; c <= 22; c++) begin
            step((c == 10) || (c == 12) || (c == 17));
            o = c + 1;
            el = (o >= 11) && (o <= 14);
            eb = (o >= 11) && (o <= 17);
            ed = (o == 13) || (o == 18);
            checks++;
            if ({led, busy, drop, pend} !== {el, eb, ed, zp}) begin
                errors++;
                $display("FAIL noqueue_drop cycle %0d: got %b expected %b", o, {led, busy, drop, pend}, {el, eb, ed, zp});
            end
        end
    endtask

    task automatic test_queue_fill();
        logic [PW-1:0] ep;
        logic el, eb;
        int o;
        do_reset();
        for (int c = 10; c <= 34; c++) begin
            step((c == 10) || (c == 12) || (c == 13));
            o = c + 1;
            el = (o >= 11) && (o < 32) && (((o - 11) % 7) < 4);
            eb = (o >= 11) && (o <= 31);
            ep = (o < 13) ? PW'(0) : (o == 13) ? PW'(1) : (o < 18) ? PW'(2) : (o < 25) ? PW'(1) : PW'(0);
            checks++;
            if ({led, busy, drop, pend} !== {el, eb, 1'b0, ep}) begin
                errors++;
                $display("FAIL queue_fill cycle %0d: got %b expected %b", o, {led, busy, drop, pend}, {el, eb, 1'b0, ep});
            end
        end
    endtask

    task automatic test_overflow();
        logic [PW-1:0] ep;
        logic el, eb, ed;
        int o;
        do_reset();
        for (int c = 10; c <= 34; c++) begin
            step((c >= 10) && (c <= 13));
            o = c + 1;
            el = (o >= 11) && (o < 32) && (((o - 11) % 7) < 4);
            eb = (o >= 11) && (o <= 31);
            ed = (o == 14);
            ep = (o < 12) ? PW'(0) : (o == 12) ? PW'(1) : (o < 18) ? PW'(2) : (o < 25) ? PW'(1) : PW'(0);
            checks++;
            if ({led, busy, drop, pend} !== {el, eb, ed, ep}) begin
                errors++;
                $display("FAIL overflow cycle %0d: got %b expected %b", o, {led, busy, drop, pend}, {el, eb, ed, ep});
            end
        end
    endtask

    task automatic test_last_off();
        logic [PW-1:0] ep;
        logic el, eb;
        int o;
        do_reset();
        for (int c = 10; c <= 34; c++) begin
            step((c == 10) || (c == 12) || (c == 17));
            o = c + 1;
            el = (o >= 11) && (o < 32) && (((o - 11) % 7) < 4);
            eb = (o >= 11) && (o <= 31);
            ep = (o < 13) ? PW'(0) : (o < 25) ? PW'(1) : PW'(0);
            checks++;
            if ({led, busy, drop, pend} !== {el, eb, 1'b0, ep}) begin
                errors++;
                $display("FAIL last_off cycle %0d: got %b expected %b", o, {led, busy, drop, pend}, {el, eb, 1'b0, ep});
            end
        end
    endtask

    task automatic test_async_reset();
        logic [PW+2:0] zero;
        logic [PW-1:0] ep;
        zero = '0;
        do_reset();
        step(1'b1);
`ifdef LED_FLASH_QUEUE_EN
        step(1'b1);
        step(1'b1);
        ep = PW'(2);
`else
        step(1'b0);
        step(1'b0);
        ep = PW'(0);
`endif
        checks++;
        if ({led, busy, pend} !== {1'b1, 1'b1, ep}) begin
            errors++;
            $display("FAIL async_pre: got %b expected %b", {led, busy, pend}, {1'b1, 1'b1, ep});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({led, busy, drop, pend} !== zero) begin
            errors++;
            $display("FAIL async_assert: got %b expected %b", {led, busy, drop, pend}, zero);
        end
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step(1'b0);
            checks++;
            if ({led, busy, drop, pend} !== zero) begin
                errors++;
                $display("FAIL async_release[%0d]: got %b expected %b", k, {led, busy, drop, pend}, zero);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
`ifdef LED_FLASH_QUEUE_EN
        test_queue_fill();
        test_overflow();
        test_last_off();
`else
        test_noqueue_drop();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_flash_driver.md
LED_FLASH_DRIVER -- requirements
Module: led_flash_driver

Interface
REQ-001 Parameter ON_CYCLES, default 25_000_000, number of clock cycles o_led is high per flash (250 ms at 100 MHz); SHALL be >= 1.
REQ-002 Parameter OFF_CYCLES, default 25_000_000, number of clock cycles of forced low gap after each flash; SHALL be >= 1.
REQ-003 Parameter QUEUE_MAX, default 7, maximum number of queued pending flashes; SHALL be >= 1.
REQ-004 i_clk  input  1  100 MHz system clock; all logic SHALL be on its rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_trig  input  1  single-cycle flash request (debounced press pulse); sampled every rising edge.
REQ-007 o_led  output  1  registered LED drive, high during a flash ON phase.
REQ-008 o_busy  output  1  high whenever the FSM is not IDLE.
REQ-009 o_pending  output  $clog2(QUEUE_MAX+1)  count of queued flashes not yet started.
REQ-010 o_drop  output  1  one-cycle pulse when an i_trig is discarded.

Function
REQ-011 FSM states SHALL be IDLE, ON, OFF; o_led high only in ON, o_busy = (state != IDLE).
REQ-012 IDLE with i_trig=1 SHALL go to ON; o_led high on the first edge after the edge sampling i_trig (latency 1 cycle); o_pending unchanged.
REQ-013 ON SHALL last exactly ON_CYCLES cycles, then go to OFF; OFF SHALL last exactly OFF_CYCLES cycles.
REQ-014 Timer SHALL be $clog2(max(ON_CYCLES,OFF_CYCLES)) bits wide, cleared on every state entry, no wrap within a phase.
REQ-015 On the last OFF cycle: if o_pending > 0, go to ON and decrement o_pending; else if i_trig=1 (queue enabled), go to ON without touching o_pending; else go to IDLE.
REQ-016 With queue enabled, i_trig in ON or OFF (other than the REQ-015 case) SHALL increment o_pending.
REQ-017 Simultaneous i_trig and decrement SHALL leave o_pending unchanged (net zero), never drop.
REQ-018 i_trig with o_pending = QUEUE_MAX and no same-cycle decrement SHALL be discarded: o_pending saturates, o_drop pulses one cycle later.
REQ-019 Back-to-back flashes SHALL be gapless apart from OFF: o_led period = ON_CYCLES + OFF_CYCLES.
REQ-020 o_drop SHALL be registered and high for exactly one cycle per discarded trigger.

Reset
REQ-021 i_rst_n low SHALL immediately force state IDLE, timer 0, o_led 0, o_busy 0, o_pending 0, o_drop 0, independent of i_clk.
REQ-022 Reset mid-flash SHALL abort the flash and discard all pending flashes; release SHALL be synchronous to the next rising edge with no spurious o_led pulse.

Configuration
REQ-023 Macro LED_FLASH_QUEUE_EN defined: pending queue per REQ-015..REQ-018 compiled in.
REQ-024 Macro undefined: no queue logic; i_trig accepted only in IDLE; any i_trig in ON or OFF SHALL be discarded with o_drop pulse; o_pending tied to 0.

Verification (ON_CYCLES=4, OFF_CYCLES=3, QUEUE_MAX=2)
REQ-025 Single i_trig at cycle 10 in IDLE -> o_led high cycles 11-14, low 15-17, o_busy high 11-17, IDLE at 18, o_drop never set.
REQ-026 (queue on) i_trig at 10, 12, 13 -> o_pending 1 then 2; three flashes, o_led rising at 11, 18, 25; o_pending 0 at end.
REQ-027 (queue on) i_trig at 10, 11, 12, 13 -> fourth trigger dropped, o_drop high at cycle 14 only, o_pending stays 2.
REQ-028 (queue on) o_pending=1, i_trig on last OFF cycle -> o_pending remains 1, next ON starts next cycle.
REQ-029 (queue off) i_trig at 10 and 12 -> one flash only, o_drop high at cycle 13, o_pending always 0.
REQ-030 i_rst_n low mid-ON with o_pending=2, released 5 cycles later -> o_led drops asynchronously, all outputs 0, no flash until next i_trig.
